// File: rtl/mixed_vec_serializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mixed_vec_serializer_if                                       |
// | Brief    : Frame-in / beat-out handshake bundle for the MixedVec         |
// |            serializer. master = stimulus/harness side, slave = block.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface mixed_vec_serializer_if #(
  parameter int IN_W  = 40,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_bits;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_bits;
  logic [1:0]       out_idx;
  logic             out_last;
  logic [7:0]       frame_count;

  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_bits, out_idx, out_last, frame_count
  );

  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_bits, out_idx, out_last, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/mixed_vec_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mixed_vec_serializer                                          |
// | Brief    : Captures one frame of four mixed-width elements and emits     |
// |            them one per beat, zero-extended to OUT_W, with index, last   |
// |            flag and a wrapping completed-frame counter.                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mixed_vec_serializer #(
  parameter int W0    = 8,
  parameter int W1    = 16,
  parameter int W2    = 4,
  parameter int W3    = 12,
  parameter int OUT_W = 16   // must be at least max(W0..W3)
) (
  input  logic                  clock,
  input  logic                  reset,   // asynchronous, active-low
  mixed_vec_serializer_if.slave bus
);

  localparam int c_IN_W = W0 + W1 + W2 + W3;
  localparam int c_OFF0 = 0;
  localparam int c_OFF1 = W0;
  localparam int c_OFF2 = W0 + W1;
  localparam int c_OFF3 = W0 + W1 + W2;
  localparam logic [1:0] c_LAST_IDX = 2'd3;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [c_IN_W-1:0] r_capture;
  logic [1:0]        r_idx;
  logic [7:0]        r_frame_count;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_take;
  logic              w_beat_fire;
  logic              w_frame_done;
  logic [OUT_W-1:0]  w_elem;

  // State register; reset drops any partially sent frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode. in_ready is gated by reset so it reads
  // low for the whole time reset is held, and only depends on registered
  // state otherwise (no path from out_ready).
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_take       = 1'b0;
    w_beat_fire  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = reset;
        w_take     = bus.in_valid & reset;
        if (w_take) begin
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        w_out_valid = 1'b1;
        w_beat_fire = bus.out_ready;
        if (w_beat_fire && (r_idx == c_LAST_IDX)) begin
          w_frame_done = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Capture register only loads on an accepted frame; in_valid in SEND is ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_capture <= '0;
    end else if (w_take) begin
      r_capture <= bus.in_bits;
    end
  end

  // Beat index: restart at 0 on capture, advance on each fired beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx <= 2'd0;
    end else if (w_take) begin
      r_idx <= 2'd0;
    end else if (w_beat_fire) begin
      r_idx <= r_idx + 2'd1;   // wraps 3 -> 0 on the last beat
    end
  end

  // Completed-frame counter, wraps modulo 256.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frame_count <= 8'd0;
    end else if (w_frame_done) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  // Element select from the captured frame, zero-extended to the bus width.
  always_comb begin
    w_elem = '0;
    case (r_idx)
      2'd0:    w_elem = OUT_W'(r_capture[c_OFF0 +: W0]);
      2'd1:    w_elem = OUT_W'(r_capture[c_OFF1 +: W1]);
      2'd2:    w_elem = OUT_W'(r_capture[c_OFF2 +: W2]);
      default: w_elem = OUT_W'(r_capture[c_OFF3 +: W3]);
    endcase
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_bits    = w_elem;
  assign bus.out_idx     = r_idx;
  assign bus.out_last    = (r_idx == c_LAST_IDX);
  assign bus.frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_mixed_vec_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mixed_vec_serializer                                       |
// | Brief    : Self-checking bench: directed frames plus random traffic      |
// |            against a queue-based model of the serializer.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mixed_vec_serializer;

  localparam int c_W0 = 8;
  localparam int c_W1 = 16;
  localparam int c_W2 = 4;
  localparam int c_W3 = 12;
  localparam int c_OUT_W = 16;
  localparam int c_IN_W = c_W0 + c_W1 + c_W2 + c_W3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: beats still owed by the block, head first, plus frames completed.
  int unsigned exp_q[$];
  int unsigned exp_count = 0;

  mixed_vec_serializer_if #(.IN_W(c_IN_W), .OUT_W(c_OUT_W)) bus ();

  mixed_vec_serializer #(
    .W0(c_W0), .W1(c_W1), .W2(c_W2), .W3(c_W3), .OUT_W(c_OUT_W)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Single comparison point: counts every check, reports mismatches.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Split a frame into its four elements by plain arithmetic on widths.
  function automatic int unsigned elem_of(input logic [c_IN_W-1:0] f, input int k);
    longint unsigned v;
    int off;
    int w;
    v = 64'(f);
    off = 0;
    for (int j = 0; j < k; j++) off += (j == 0) ? c_W0 : (j == 1) ? c_W1 : c_W2;
    w = (k == 0) ? c_W0 : (k == 1) ? c_W1 : (k == 2) ? c_W2 : c_W3;
    return int'((v >> off) % (64'd1 << w));
  endfunction

  // Monitor at the falling edge: compare outputs to the model, then advance
  // the model by what the next rising edge will do with the current inputs.
  always @(negedge clock) begin
    if (!reset) begin
      check("rst_in_ready",  64'(bus.in_ready),    64'd0);
      check("rst_out_valid", 64'(bus.out_valid),   64'd0);
      check("rst_out_bits",  64'(bus.out_bits),    64'd0);
      check("rst_out_idx",   64'(bus.out_idx),     64'd0);
      check("rst_out_last",  64'(bus.out_last),    64'd0);
      check("rst_count",     64'(bus.frame_count), 64'd0);
      exp_q.delete();
      exp_count = 0;
    end else begin
      check("in_ready",    64'(bus.in_ready),    64'(exp_q.size() == 0));
      check("out_valid",   64'(bus.out_valid),   64'(exp_q.size() != 0));
      check("frame_count", 64'(bus.frame_count), 64'(exp_count % 256));
      if (exp_q.size() != 0) begin
        check("out_bits", 64'(bus.out_bits), 64'(exp_q[0]));
        check("out_idx",  64'(bus.out_idx),  64'(4 - exp_q.size()));
        check("out_last", 64'(bus.out_last), 64'(exp_q.size() == 1));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) exp_count++;
        end
      end else if (bus.in_valid) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(elem_of(bus.in_bits, k));
      end
    end
  end

  // One stimulus cycle: inputs change just after the rising edge.
  task automatic cyc(input logic v, input logic [c_IN_W-1:0] b, input logic rdy);
    @(posedge clock);
    #1;
    bus.in_valid  = v;
    bus.in_bits   = b;
    bus.out_ready = rdy;
  endtask

  function automatic logic [c_IN_W-1:0] rand_frame();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[c_IN_W-1:0];
  endfunction

  localparam logic [c_IN_W-1:0] c_PAT = 40'hABCC1234A5;
  localparam logic [c_IN_W-1:0] c_ONES = 40'hFFFFFFFFFF;

  initial begin
    int waited;
    bool_pat: begin end
    bus.in_valid  = 1'b0;
    bus.in_bits   = '0;
    bus.out_ready = 1'b0;

    // Reset low for three cycles, release just after an edge.
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Basic frame with out_ready held high.
    cyc(1'b1, c_PAT, 1'b1);
    cyc(1'b0, '0, 1'b1);
    repeat (4) cyc(1'b0, '0, 1'b1);
    #1;
    check("basic_count", 64'(bus.frame_count), 64'd1);
    check("basic_ready", 64'(bus.in_ready), 64'd1);

    // Backpressure pattern on the same frame.
    cyc(1'b1, c_PAT, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    #1;
    check("bp_count", 64'(bus.frame_count), 64'd2);

    // Busy input: in_valid held with alternating frames.
    for (int i = 0; i < 15; i++) cyc(1'b1, (i % 2 == 0) ? c_PAT : '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    repeat (5) cyc(1'b0, '0, 1'b1);

    // Width boundary: all ones.
    cyc(1'b1, c_ONES, 1'b1);
    repeat (6) cyc(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cyc(1'(($urandom() % 3) != 0), rand_frame(), 1'(($urandom() % 4) != 0));
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1);

    // Reset mid-frame after beat idx1 has fired.
    cyc(1'b1, c_PAT, 1'b1);
    cyc(1'b0, '0, 1'b1);
    waited = 0;
    while (exp_q.size() != 2 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check("rst_wait", 64'(exp_q.size()), 64'd2);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("mid_out_valid", 64'(bus.out_valid),   64'd0);
    check("mid_in_ready",  64'(bus.in_ready),    64'd0);
    check("mid_count",     64'(bus.frame_count), 64'd0);
    repeat (2) @(posedge clock);

    // Release and run 256 back-to-back frames; first edge after release captures.
    #1;
    reset = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bits   = c_PAT;
    bus.out_ready = 1'b1;
    repeat (1279) @(posedge clock);
    #2;
    check("wrap_255", 64'(bus.frame_count), 64'd255);
    @(posedge clock);
    #2;
    check("wrap_0", 64'(bus.frame_count), 64'd0);
    cyc(1'b0, '0, 1'b1);
    repeat (8) cyc(1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
